mfsr9_fifo_ctrl: RTL and testbench

Read/write pointer and flag controller for a 511-entry synchronous FIFO whose RAM is addressed in 9-bit maximal-length feedback-shift-register (MFSR) order instead of binary.
- Both pointers advance by a single-cycle LFSR step rather than a carry chain.
- Pointer values feed the RAM address pins directly.
- Any pointer can be mapped to or from binary by the existing combinational `mfsr9`/`imfsr9` converters downstream.
- A binary occupancy count and full/empty/threshold/error flags are maintained alongside the pointers.

---
 rtl/mfsr9_fifo_ctrl_if.sv | 31 +++
 rtl/mfsr9_fifo_ctrl.sv | 97 +++++++++
 tb/tb_mfsr9_fifo_ctrl.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mfsr9_fifo_ctrl_if.sv
// Request/status bundle between a FIFO user and the MFSR-addressed pointer/flag controller.
interface mfsr9_fifo_ctrl_if;
    localparam int unsigned PTR_W = 9;

    logic             wr_i;
    logic             rd_i;
    logic             clr_err_i;
    logic [PTR_W-1:0] wr_ptr_o;
    logic [PTR_W-1:0] rd_ptr_o;
    logic             wr_en_o;
    logic             rd_en_o;
    logic [PTR_W-1:0] level_o;
    logic             full_o;
    logic             empty_o;
    logic             afull_o;
    logic             aempty_o;
    logic             ovf_o;
    logic             unf_o;

    modport slave (
        input  wr_i, rd_i, clr_err_i,
        output wr_ptr_o, rd_ptr_o, wr_en_o, rd_en_o, level_o,
               full_o, empty_o, afull_o, aempty_o, ovf_o, unf_o
    );

    modport master (
        output wr_i, rd_i, clr_err_i,
        input  wr_ptr_o, rd_ptr_o, wr_en_o, rd_en_o, level_o,
               full_o, empty_o, afull_o, aempty_o, ovf_o, unf_o
    );
endinterface

// File: rtl/mfsr9_fifo_ctrl.sv
// Pointer, occupancy and flag controller for a 511-entry FIFO whose RAM is addressed in 9-bit MFSR order.
module mfsr9_fifo_ctrl #(
    parameter int unsigned AFULL  = 480,
    parameter int unsigned AEMPTY = 16
) (
    input  logic                clock_i,
    input  logic                reset_i,
    mfsr9_fifo_ctrl_if.slave    bus
);
    localparam int unsigned PTR_W = 9;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(1);
    localparam logic [PTR_W-1:0] LVL_MAX  = PTR_W'(511);
    localparam logic [PTR_W-1:0] AFULL_L  = PTR_W'(AFULL);
    localparam logic [PTR_W-1:0] AEMPTY_L = PTR_W'(AEMPTY);

    // x^9 + x^5 + 1 shift step, period 511; all-zeros is unreachable from PTR_RST
    function automatic logic [PTR_W-1:0] mfsr_next(input logic [PTR_W-1:0] q);
        return {q[7:0], q[8] ^ q[4]};
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] level_q,  level_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             afull_q,  afull_d;
    logic             aempty_q, aempty_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;
    logic             wr_en_c,  rd_en_c;

    always_comb begin
        wr_en_c  = 1'b0;
        rd_en_c  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        // A read alongside a write frees the slot when full; reads never fall through when empty
        wr_en_c = bus.wr_i & (~full_q | bus.rd_i);
        rd_en_c = bus.rd_i & ~empty_q;

        if (wr_en_c) wr_ptr_d = mfsr_next(wr_ptr_q);
        if (rd_en_c) rd_ptr_d = mfsr_next(rd_ptr_q);

        if (wr_en_c && !rd_en_c) begin
            level_d = level_q + PTR_W'(1);
        end else if (!wr_en_c && rd_en_c) begin
            level_d = level_q - PTR_W'(1);
        end

        full_d   = (level_d == LVL_MAX);
        empty_d  = (level_d == '0);
        afull_d  = (level_d >= AFULL_L);
        aempty_d = (level_d <= AEMPTY_L);

        // Sticky errors: a new event in the clearing cycle wins over the clear
        ovf_d = (bus.wr_i & full_q & ~bus.rd_i) | (ovf_q & ~bus.clr_err_i);
        unf_d = (bus.rd_i & empty_q)            | (unf_q & ~bus.clr_err_i);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= PTR_RST;
            rd_ptr_q <= PTR_RST;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign bus.wr_ptr_o = wr_ptr_q;
    assign bus.rd_ptr_o = rd_ptr_q;
    assign bus.wr_en_o  = wr_en_c;
    assign bus.rd_en_o  = rd_en_c;
    assign bus.level_o  = level_q;
    assign bus.full_o   = full_q;
    assign bus.empty_o  = empty_q;
    assign bus.afull_o  = afull_q;
    assign bus.aempty_o = aempty_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.unf_o    = unf_q;
endmodule

// File: tb/tb_mfsr9_fifo_ctrl.sv
// Directed and scoreboard-checked bench for the MFSR9 FIFO pointer/flag controller.
module tb_mfsr9_fifo_ctrl;
    localparam int unsigned AFULL  = 480;
    localparam int unsigned AEMPTY = 16;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [8:0] seq [0:510];
    int         pos_of [0:511];

    mfsr9_fifo_ctrl_if bus ();

    mfsr9_fifo_ctrl #(.AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic build_tables();
        logic [8:0] q;
        q = 9'h001;
        for (int i = 0; i < 512; i++) pos_of[i] = -1;
        for (int i = 0; i < 511; i++) begin
            seq[i]    = q;
            pos_of[q] = i;
            q         = {q[7:0], q[8] ^ q[4]};
        end
    endtask

    task automatic test_reset();
        bus.wr_i = 1'b1; bus.rd_i = 1'b1; bus.clr_err_i = 1'b0; reset_i = 1'b1;
        tick();
        reset_i = 1'b0; bus.wr_i = 1'b0; bus.rd_i = 1'b0;
        n_total++;
        if ({bus.wr_ptr_o, bus.rd_ptr_o} !== {9'h001, 9'h001})
            $display("FAIL reset_ptrs: got %h/%h expected 001/001", bus.wr_ptr_o, bus.rd_ptr_o);
        else n_pass++;
        n_total++;
        if (bus.level_o !== 9'd0) $display("FAIL reset_level: got %0d expected 0", bus.level_o);
        else n_pass++;
        n_total++;
        if ({bus.full_o, bus.empty_o, bus.afull_o, bus.aempty_o, bus.ovf_o, bus.unf_o} !== 6'b010100)
            $display("FAIL reset_flags: got %b expected 010100",
                     {bus.full_o, bus.empty_o, bus.afull_o, bus.aempty_o, bus.ovf_o, bus.unf_o});
        else n_pass++;
    endtask

    task automatic test_pointer_seq();
        logic [8:0] exp_ptr [0:5];
        exp_ptr = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h021};
        for (int i = 0; i < 6; i++) begin
            bus.wr_i = 1'b1;
            #1;
            n_total++;
            if ({bus.wr_en_o, bus.wr_ptr_o} !== {1'b1, exp_ptr[i]})
                $display("FAIL ptr_seq[%0d]: got en=%b ptr=%h expected en=1 ptr=%h",
                         i, bus.wr_en_o, bus.wr_ptr_o, exp_ptr[i]);
            else n_pass++;
            tick();
        end
        bus.wr_i = 1'b0;
        n_total++;
        if (bus.level_o !== 9'd6) $display("FAIL ptr_seq_level: got %0d expected 6", bus.level_o);
        else n_pass++;
        n_total++;
        if (bus.rd_ptr_o !== 9'h001) $display("FAIL ptr_seq_rdptr: got %h expected 001", bus.rd_ptr_o);
        else n_pass++;
    endtask

    task automatic test_fill();
        bit seen [0:511];
        int repeats = 0;
        int strobe_bad = 0;
        for (int i = 0; i < 512; i++) seen[i] = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 1; i <= 511; i++) begin
            bus.wr_i = 1'b1;
            #1;
            if (seen[bus.wr_ptr_o]) repeats++;
            seen[bus.wr_ptr_o] = 1'b1;
            if (bus.wr_en_o !== 1'b1) strobe_bad++;
            tick();
            if (i == 16 || i == 17) begin
                n_total++;
                if (bus.aempty_o !== (i == 16))
                    $display("FAIL fill_aempty_at_%0d: got %b expected %b", i, bus.aempty_o, i == 16);
                else n_pass++;
            end
            if (i == 479 || i == 480) begin
                n_total++;
                if (bus.afull_o !== (i == 480))
                    $display("FAIL fill_afull_at_%0d: got %b expected %b", i, bus.afull_o, i == 480);
                else n_pass++;
            end
        end
        n_total++;
        if ({repeats, strobe_bad} !== {32'd0, 32'd0})
            $display("FAIL fill_unique: got repeats=%0d strobe_misses=%0d expected 0/0", repeats, strobe_bad);
        else n_pass++;
        n_total++;
        if ({bus.full_o, bus.level_o, bus.wr_ptr_o} !== {1'b1, 9'd511, 9'h001})
            $display("FAIL fill_full: got full=%b level=%0d wr_ptr=%h expected 1/511/001",
                     bus.full_o, bus.level_o, bus.wr_ptr_o);
        else n_pass++;
        #1;
        n_total++;
        if (bus.wr_en_o !== 1'b0) $display("FAIL overflow_strobe: got %b expected 0", bus.wr_en_o);
        else n_pass++;
        tick();
        bus.wr_i = 1'b0;
        n_total++;
        if ({bus.ovf_o, bus.level_o} !== {1'b1, 9'd511})
            $display("FAIL overflow_flag: got ovf=%b level=%0d expected 1/511", bus.ovf_o, bus.level_o);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        int strobe_bad = 0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_i = 1'b1; bus.rd_i = 1'b1;
            #1;
            if ({bus.wr_en_o, bus.rd_en_o} !== 2'b11) strobe_bad++;
            tick();
        end
        bus.wr_i = 1'b0; bus.rd_i = 1'b0;
        n_total++;
        if (strobe_bad !== 0) $display("FAIL full_rw_strobes: got %0d missed cycles expected 0", strobe_bad);
        else n_pass++;
        n_total++;
        if ({bus.full_o, bus.level_o} !== {1'b1, 9'd511})
            $display("FAIL full_rw_level: got full=%b level=%0d expected 1/511", bus.full_o, bus.level_o);
        else n_pass++;
        n_total++;
        if ({bus.wr_ptr_o, bus.rd_ptr_o} !== {9'h008, 9'h008})
            $display("FAIL full_rw_ptrs: got %h/%h expected 008/008", bus.wr_ptr_o, bus.rd_ptr_o);
        else n_pass++;
    endtask

    task automatic test_empty_rw();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        bus.wr_i = 1'b1; bus.rd_i = 1'b1;
        #1;
        n_total++;
        if ({bus.wr_en_o, bus.rd_en_o} !== 2'b10)
            $display("FAIL empty_rw_strobes: got wr_en=%b rd_en=%b expected 1/0", bus.wr_en_o, bus.rd_en_o);
        else n_pass++;
        tick();
        bus.wr_i = 1'b0; bus.rd_i = 1'b0;
        n_total++;
        if ({bus.level_o, bus.empty_o, bus.unf_o} !== {9'd1, 1'b0, 1'b1})
            $display("FAIL empty_rw_state: got level=%0d empty=%b unf=%b expected 1/0/1",
                     bus.level_o, bus.empty_o, bus.unf_o);
        else n_pass++;
        bus.clr_err_i = 1'b1; bus.rd_i = 1'b1;
        #1;
        n_total++;
        if (bus.rd_en_o !== 1'b1) $display("FAIL clr_read_strobe: got %b expected 1", bus.rd_en_o);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.unf_o, bus.empty_o, bus.level_o} !== {1'b0, 1'b1, 9'd0})
            $display("FAIL clr_read_state: got unf=%b empty=%b level=%0d expected 0/1/0",
                     bus.unf_o, bus.empty_o, bus.level_o);
        else n_pass++;
        // clr and rd still held: empty read re-sets unf in the clearing cycle
        tick();
        n_total++;
        if (bus.unf_o !== 1'b1) $display("FAIL set_beats_clear: got unf=%b expected 1", bus.unf_o);
        else n_pass++;
        bus.rd_i = 1'b0;
        tick();
        bus.clr_err_i = 1'b0;
        n_total++;
        if (bus.unf_o !== 1'b0) $display("FAIL clear_alone: got unf=%b expected 0", bus.unf_o);
        else n_pass++;
    endtask

    task automatic test_soak();
        int wpos = 0, rpos = 0, lvl = 0, pw, d;
        bit m_ovf = 0, m_unf = 0, w, r, c, rst, wacc, racc;
        logic [32:0] got, exp;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            got = {bus.wr_ptr_o, bus.rd_ptr_o, bus.level_o, bus.full_o, bus.empty_o,
                   bus.afull_o, bus.aempty_o, bus.ovf_o, bus.unf_o};
            exp = {seq[wpos], seq[rpos], 9'(lvl), lvl == 511, lvl == 0,
                   lvl >= int'(AFULL), lvl <= int'(AEMPTY), m_ovf, m_unf};
            n_total++;
            if (got !== exp) $display("FAIL soak_state@%0d: got %h expected %h", cyc, got, exp);
            else n_pass++;
            d = (pos_of[bus.wr_ptr_o] - pos_of[bus.rd_ptr_o] + 511) % 511;
            n_total++;
            if (d !== int'(bus.level_o) % 511)
                $display("FAIL soak_ptr_gap@%0d: got %0d expected %0d", cyc, d, int'(bus.level_o) % 511);
            else n_pass++;

            pw  = ((cyc / 1500) % 2 == 0) ? 75 : 25;
            w   = ($urandom_range(99) < pw);
            r   = ($urandom_range(99) < (100 - pw));
            c   = ($urandom_range(63) == 0);
            rst = (cyc == 10000);
            bus.wr_i = w; bus.rd_i = r; bus.clr_err_i = c; reset_i = rst;
            #1;
            wacc = w && (lvl < 511 || r);
            racc = r && (lvl > 0);
            n_total++;
            if ({bus.wr_en_o, bus.rd_en_o} !== {wacc, racc})
                $display("FAIL soak_strobes@%0d: got %b%b expected %b%b",
                         cyc, bus.wr_en_o, bus.rd_en_o, wacc, racc);
            else n_pass++;

            if (rst) begin
                wpos = 0; rpos = 0; lvl = 0; m_ovf = 0; m_unf = 0;
            end else begin
                m_ovf = (w && lvl == 511 && !r) || (m_ovf && !c);
                m_unf = (r && lvl == 0) || (m_unf && !c);
                if (wacc) wpos = (wpos + 1) % 511;
                if (racc) rpos = (rpos + 1) % 511;
                lvl = lvl + int'(wacc) - int'(racc);
            end
            @(posedge clock_i);
            #1;
        end
        bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.clr_err_i = 1'b0; reset_i = 1'b0;
    endtask

    initial begin
        bus.wr_i = 1'b0; bus.rd_i = 1'b0; bus.clr_err_i = 1'b0;
        build_tables();
        test_reset();
        test_pointer_seq();
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_soak();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
